// File: rtl/timer_unit_pkg.sv
// timer_unit_pkg
//   Shared constants and types for the DMG timer block: the MMU-visible register
//   addresses, the FSM state encoding, the TAC clock-select encoding and the
//   divider tap helper.
package timer_unit_pkg;

    localparam logic [15:0] TIMER_DIV_addr  = 16'hFF04;
    localparam logic [15:0] TIMER_TIMA_addr = 16'hFF05;
    localparam logic [15:0] TIMER_TMA_addr  = 16'hFF06;
    localparam logic [15:0] TIMER_TAC_addr  = 16'hFF07;

    typedef enum logic [1:0] {
        TIMER_RUN,
        TIMER_OVF,
        TIMER_RELOAD
    } timer_state_t;

    typedef enum logic [1:0] {
        CLK_1024,
        CLK_16,
        CLK_64,
        CLK_256
    } timer_clk_sel_t;

    // Divider bit whose falling edge clocks TIMA for a given clock select.
    function automatic logic tap_bit(input logic [15:0] div, input timer_clk_sel_t sel);
        case (sel)
            CLK_16:  return div[3];
            CLK_64:  return div[5];
            CLK_256: return div[7];
            default: return div[9];
        endcase
    endfunction

endpackage

// File: rtl/timer_unit.sv
// timer_unit
//   DMG timer: free-running 16-bit system divider plus the DIV/TIMA/TMA/TAC
//   registers at $FF04-$FF07. TIMA counts falling edges of a divider tap selected
//   by TAC; an overflow reloads TIMA from TMA and raises timer_req after a short
//   delay, during which a CPU write to TIMA cancels the reload.
// Ports
//   clk        T-cycle clock
//   reset      asynchronous, active-low reset
//   addr       CPU bus address
//   wdata      CPU write data
//   read_en    read strobe (MMU-qualified); only checked by an assertion
//   write_en   write strobe (MMU-qualified)
//   rdata      read data, combinational from addr
//   timer_req  one-cycle interrupt request to IF bit 2
//
// state        | meaning
// TIMER_RUN    | normal counting
// TIMER_OVF    | TIMA overflowed, reads 00, reload pending (cnt counts down)
// TIMER_RELOAD | single cycle: TIMA <= TMA, timer_req high
module timer_unit
    import timer_unit_pkg::*;
#(
    parameter int RELOAD_DELAY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        read_en,
    input  logic        write_en,
    output logic [7:0]  rdata,
    output logic        timer_req
);

    localparam int CNT_W = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELOAD_DELAY - 1);

    logic [15:0]      div_cnt, div_nxt;
    logic [7:0]       tima, tima_nxt;
    logic [7:0]       tma, tma_nxt;
    logic [2:0]       tac, tac_nxt;
    logic             t_prev, t_in;
    logic             fall;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    timer_state_t     state, state_nxt;

    logic div_wr, tima_wr, tma_wr, tac_wr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            tima    <= '0;
            tma     <= '0;
            tac     <= '0;
            t_prev  <= 1'b0;
            cnt     <= '0;
            state   <= TIMER_RUN;
        end else begin
            div_cnt <= div_nxt;
            tima    <= tima_nxt;
            tma     <= tma_nxt;
            tac     <= tac_nxt;
            t_prev  <= t_in;
            cnt     <= cnt_nxt;
            state   <= state_nxt;
        end
    end

    always_comb begin
        div_wr  = write_en && (addr == TIMER_DIV_addr);
        tima_wr = write_en && (addr == TIMER_TIMA_addr);
        tma_wr  = write_en && (addr == TIMER_TMA_addr);
        tac_wr  = write_en && (addr == TIMER_TAC_addr);

        // A TAC write takes effect on the edge detector in the same cycle, so
        // disabling the timer or moving the tap off a high bit yields an edge.
        tac_nxt = tac_wr ? wdata[2:0] : tac;
        t_in    = tac_nxt[2] & tap_bit(div_cnt, timer_clk_sel_t'(tac_nxt[1:0]));
        // A DIV reset drops the tap to 0 next cycle, so that glitch is seen here too.
        fall    = t_prev & ~t_in;

        div_nxt   = div_wr ? 16'h0000 : div_cnt + 16'd1;
        tma_nxt   = tma_wr ? wdata : tma;
        tima_nxt  = tima;
        cnt_nxt   = cnt;
        state_nxt = state;
        timer_req = 1'b0;

        case (state)
            TIMER_RUN: begin
                if (tima_wr) begin
                    tima_nxt = wdata;
                end else if (fall) begin
                    if (tima == 8'hFF) begin
                        tima_nxt  = 8'h00;
                        cnt_nxt   = CNT_LAST;
                        state_nxt = TIMER_OVF;
                    end else begin
                        tima_nxt = tima + 8'd1;
                    end
                end
            end
            TIMER_OVF: begin
                if (tima_wr) begin
                    tima_nxt  = wdata;
                    state_nxt = TIMER_RUN;
                end else begin
                    if (fall) begin
                        tima_nxt = tima + 8'd1;
                    end
                    if (cnt == '0) begin
                        state_nxt = TIMER_RELOAD;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            TIMER_RELOAD: begin
                // TMA wins over a TIMA write; a TMA write lands in both.
                timer_req = 1'b1;
                tima_nxt  = tma_nxt;
                state_nxt = TIMER_RUN;
            end
            default: begin
                state_nxt = TIMER_RUN;
            end
        endcase

        case (addr)
            TIMER_DIV_addr:  rdata = div_cnt[15:8];
            TIMER_TIMA_addr: rdata = tima;
            TIMER_TMA_addr:  rdata = tma;
            TIMER_TAC_addr:  rdata = {5'b11111, tac};
            default:         rdata = 8'hFF;
        endcase
    end

    a_no_rw_overlap: assert property (@(posedge clk) disable iff (!reset)
        !(read_en && write_en));

endmodule

// File: tb/tb_timer_unit.sv
module tb_timer_unit;
    import timer_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic [7:0]  rdata;
    logic        timer_req;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    timer_unit dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .read_en(read_en), .write_en(write_en), .rdata(rdata), .timer_req(timer_req)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr = a; wdata = d; read_en = 1'b0; write_en = 1'b1;
        tick(1);
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        addr = a; read_en = 1'b1;
        #1;
        d = rdata;
        read_en = 1'b0;
    endtask

    // Leaves the divider at 1 with the new TAC in place and no pending edge.
    task automatic setup(input logic [7:0] t, input logic [7:0] m, input logic [7:0] c);
        wr(TIMER_TAC_addr, 8'h00);
        wr(TIMER_TIMA_addr, t);
        wr(TIMER_TMA_addr, m);
        wr(TIMER_DIV_addr, 8'h00);
        wr(TIMER_TAC_addr, c);
    endtask

    task automatic test_reset;
        logic [7:0] got, exp;
        reset = 1'b0;
        tick(3);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'hF8); exp_q.push_back(8'h00);
        rd(TIMER_DIV_addr, got);  exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_div got=%h exp=%h", got, exp); end
        rd(TIMER_TIMA_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_tima got=%h exp=%h", got, exp); end
        rd(TIMER_TMA_addr, got);  exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_tma got=%h exp=%h", got, exp); end
        rd(TIMER_TAC_addr, got);  exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_tac got=%h exp=%h", got, exp); end
        got = {7'b0, timer_req};  exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_req got=%h exp=%h", got, exp); end
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_overflow_reload;
        logic [7:0] got, exp;
        int n_req = 0;
        int req_div = -1;
        setup(8'hFE, 8'h20, 8'h05);
        // TIMA at divider values 16, 17, 32, 33, 37, 38
        exp_q.push_back(8'hFE); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h20);
        for (int d = 2; d <= 45; d++) begin
            tick(1);
            if (timer_req) begin n_req++; req_div = d; end
            if (d == 16 || d == 17 || d == 32 || d == 33 || d == 37 || d == 38) begin
                rd(TIMER_TIMA_addr, got); exp = exp_q.pop_front(); checks++;
                if (got !== exp) begin failures++; $display("FAIL ovf_tima div=%0d got=%h exp=%h", d, got, exp); end
            end
        end
        checks++;
        if (n_req !== 1) begin failures++; $display("FAIL ovf_req_count got=%0d exp=1", n_req); end
        checks++;
        if (req_div !== 37) begin failures++; $display("FAIL ovf_req_cycle got=%0d exp=37", req_div); end
    endtask

    task automatic test_cancel;
        logic [7:0] got, exp;
        int n_req = 0;
        setup(8'hFF, 8'h40, 8'h05);
        tick(16);
        exp_q.push_back(8'h00); exp_q.push_back(8'h55); exp_q.push_back(8'h56);
        rd(TIMER_TIMA_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL cancel_ovf got=%h exp=%h", got, exp); end
        tick(2);
        wr(TIMER_TIMA_addr, 8'h55);
        for (int i = 0; i < 10; i++) begin
            if (timer_req) n_req++;
            tick(1);
        end
        checks++;
        if (n_req !== 0) begin failures++; $display("FAIL cancel_req got=%0d exp=0", n_req); end
        rd(TIMER_TIMA_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL cancel_tima got=%h exp=%h", got, exp); end
        tick(3);
        rd(TIMER_TIMA_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL cancel_run got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reload_writes;
        logic [7:0] got, exp;
        setup(8'hFF, 8'h30, 8'h05);
        tick(20);
        exp_q.push_back(8'h01); exp_q.push_back(8'h77); exp_q.push_back(8'h77);
        got = {7'b0, timer_req}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rl_req got=%h exp=%h", got, exp); end
        wr(TIMER_TMA_addr, 8'h77);
        rd(TIMER_TIMA_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rl_tma_tima got=%h exp=%h", got, exp); end
        rd(TIMER_TMA_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rl_tma_tma got=%h exp=%h", got, exp); end

        setup(8'hFF, 8'h30, 8'h05);
        tick(20);
        exp_q.push_back(8'h01); exp_q.push_back(8'h30);
        got = {7'b0, timer_req}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rl_req2 got=%h exp=%h", got, exp); end
        wr(TIMER_TIMA_addr, 8'h11);
        rd(TIMER_TIMA_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rl_tima_ignored got=%h exp=%h", got, exp); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] got, exp;
        setup(8'h20, 8'h00, 8'h05);
        tick(15);
        wr(TIMER_TIMA_addr, 8'h60);
        exp_q.push_back(8'h60); exp_q.push_back(8'h61);
        rd(TIMER_TIMA_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL b2b_write_wins got=%h exp=%h", got, exp); end
        tick(16);
        rd(TIMER_TIMA_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL b2b_next_edge got=%h exp=%h", got, exp); end
    endtask

    task automatic test_div_write;
        logic [7:0] got, exp;
        setup(8'h10, 8'h00, 8'h05);
        tick(9);
        wr(TIMER_DIV_addr, 8'hAB);
        exp_q.push_back(8'h00); exp_q.push_back(8'h11); exp_q.push_back(8'h11); exp_q.push_back(8'h01);
        rd(TIMER_DIV_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL div_clear got=%h exp=%h", got, exp); end
        tick(1);
        rd(TIMER_TIMA_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL div_glitch got=%h exp=%h", got, exp); end
        tick(5);
        rd(TIMER_TIMA_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL div_single got=%h exp=%h", got, exp); end
        tick(250);
        rd(TIMER_DIV_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL div_count got=%h exp=%h", got, exp); end
    endtask

    task automatic test_tac_glitch;
        logic [7:0] got, exp;
        setup(8'h40, 8'h00, 8'h04);
        tick(600);
        exp_q.push_back(8'h40); exp_q.push_back(8'h41); exp_q.push_back(8'h41); exp_q.push_back(8'hFC);
        rd(TIMER_TIMA_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL tac_hold got=%h exp=%h", got, exp); end
        wr(TIMER_TAC_addr, 8'h00);
        rd(TIMER_TIMA_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL tac_disable got=%h exp=%h", got, exp); end
        wr(TIMER_DIV_addr, 8'h00);
        wr(TIMER_TAC_addr, 8'h04);
        tick(3);
        rd(TIMER_TIMA_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL tac_reenable got=%h exp=%h", got, exp); end
        rd(TIMER_TAC_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL tac_read got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reset_in_ovf;
        logic [7:0] got, exp;
        int n_req = 0;
        setup(8'hFF, 8'h30, 8'h05);
        tick(17);
        reset = 1'b0;
        #1;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'hF8); exp_q.push_back(8'hFF);
        got = {7'b0, timer_req}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rst_ovf_req got=%h exp=%h", got, exp); end
        rd(TIMER_DIV_addr, got);  exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rst_ovf_div got=%h exp=%h", got, exp); end
        rd(TIMER_TIMA_addr, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rst_ovf_tima got=%h exp=%h", got, exp); end
        rd(TIMER_TMA_addr, got);  exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rst_ovf_tma got=%h exp=%h", got, exp); end
        rd(TIMER_TAC_addr, got);  exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rst_ovf_tac got=%h exp=%h", got, exp); end
        rd(16'hFF08, got);        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rst_ovf_unmapped got=%h exp=%h", got, exp); end
        tick(2);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (timer_req) n_req++;
        end
        checks++;
        if (n_req !== 0) begin failures++; $display("FAIL rst_ovf_no_req got=%0d exp=0", n_req); end
    endtask

    initial begin
        tick(1);
        test_reset;
        test_overflow_reload;
        test_cancel;
        test_reload_writes;
        test_back_to_back;
        test_div_write;
        test_tac_glitch;
        test_reset_in_ovf;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
